// File: rtl/struct_test_pkg.sv
// Shared sizing constants and the snapshot payload for the event statistics accumulator.
package struct_test_pkg;

  localparam int unsigned EVS_NCHAN = 4;
  localparam int unsigned EVS_DW    = 16;
  localparam int unsigned EVS_CW    = 32;

  typedef struct packed {
    logic [EVS_NCHAN-1:0][EVS_DW-1:0] peak;
    logic [EVS_NCHAN-1:0][EVS_CW-1:0] count;
    logic [EVS_CW-1:0]                samples;
  } evs_t;

endpackage

// File: rtl/event_stat_chan.sv
// One channel of working statistics: running unsigned peak and saturating threshold-event count.
// peak_c/count_c present the post-update values so a snapshot taken this cycle includes this sample.
module event_stat_chan #(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_i,
  input  logic [DW-1:0] sample_i,
  input  logic [DW-1:0] thresh_i,
  input  logic          clear_i,
  output logic [DW-1:0] peak_c,
  output logic [CW-1:0] count_c
);

  logic [DW-1:0] peak_q, peak_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    peak_d  = peak_q;
    count_d = count_q;
    if (valid_i) begin
      if (sample_i > peak_q) peak_d = sample_i;
      if ((sample_i >= thresh_i) && (count_q != {CW{1'b1}})) count_d = count_q + CW'(1);
    end
  end

  // Clear drops the working set; the updated values have already been handed to the snapshot.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      peak_q  <= '0;
      count_q <= '0;
    end else begin
      peak_q  <= peak_d;
      count_q <= count_d;
    end
  end

  assign peak_c  = peak_d;
  assign count_c = count_d;

endmodule

// File: rtl/event_stat_accum.sv
// Multi-channel event statistics accumulator with an atomic snapshot-and-clear
// offered downstream over a valid/ready handshake.
module event_stat_accum
  import struct_test_pkg::*;
#(
  parameter int unsigned NCHAN = EVS_NCHAN,
  parameter int unsigned DW    = EVS_DW,
  parameter int unsigned CW    = EVS_CW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  input  logic [NCHAN*DW-1:0] s_data,
  input  logic [DW-1:0]       threshold,
  input  logic                snap_req,
  output logic                snap_valid,
  input  logic                snap_ready,
  output evs_t                snap_stat,
  output logic                snap_ovf
);

  // The snapshot layout is fixed by the package, so the parameters must agree with it.
  if ((NCHAN != EVS_NCHAN) || (DW != EVS_DW) || (CW != EVS_CW) || (NCHAN < 1)) begin : g_bad_param
    $error("event_stat_accum: NCHAN/DW/CW must match struct_test_pkg constants");
  end

  logic                      snap_acc_c;
  logic [NCHAN-1:0][DW-1:0]  peak_c;
  logic [NCHAN-1:0][CW-1:0]  count_c;
  logic [CW-1:0]             samples_q, samples_d, samples_nxt;
  evs_t                      snap_q, snap_d;
  logic                      valid_q, valid_d;
  logic                      ovf_q, ovf_d;

  for (genvar g = 0; g < NCHAN; g++) begin : g_chan
    event_stat_chan #(
      .DW (DW),
      .CW (CW)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .valid_i  (s_valid),
      .sample_i (s_data[g*DW +: DW]),
      .thresh_i (threshold),
      .clear_i  (snap_acc_c),
      .peak_c   (peak_c[g]),
      .count_c  (count_c[g])
    );
  end

  // A request is taken only when the slot is empty or being drained this cycle.
  always_comb begin
    snap_acc_c  = snap_req && (!valid_q || snap_ready);
    samples_nxt = samples_q;
    if (s_valid && (samples_q != {CW{1'b1}})) samples_nxt = samples_q + CW'(1);
    samples_d = snap_acc_c ? '0 : samples_nxt;
    snap_d    = snap_q;
    valid_d   = valid_q;
    if (snap_acc_c) begin
      snap_d.peak    = peak_c;
      snap_d.count   = count_c;
      snap_d.samples = samples_nxt;
      valid_d        = 1'b1;
    end else if (snap_ready) begin
      valid_d = 1'b0;
    end
    ovf_d = ovf_q || (snap_req && !snap_acc_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      samples_q <= '0;
      snap_q    <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      samples_q <= samples_d;
      snap_q    <= snap_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign snap_stat  = snap_q;
  assign snap_valid = valid_q;
  assign snap_ovf   = ovf_q;

endmodule
